countdown_timer: RTL
====================

# countdown_timer

Memory-mapped, processor-writable down-counting timer for the Matrak M10 peripheral bus; the write-side companion to the free-running read-only cycle counter. Software loads a period, starts the timer and receives an expiry flag and level interrupt, with optional auto-reload for periodic ticks. Sits on the same select/data peripheral bus as the other M10 registers; read data is zero when not selected so outputs can be OR-combined.

## Interface
- PRESCALE_DIV, 16: tick divider, used only when the prescaler is compiled in; legal 2..256.
- clk_i  input  1  system clock.
- rst_i  input  1  reset; asynchronous, active-high.
- sel_i  input  1  block select from address decoder.
- we_i  input  1  write strobe; qualified by sel_i.
- addr_i  input  2  register index: 0 CTRL, 1 LOAD, 2 COUNT, 3 STATUS.
- data_i  input  32  write data from processor.
- data_o  output  32  read data; 32'b0 when sel_i=0.
- irq_o  output  1  registered level interrupt.

## Operation
- CTRL (addr 0): bit0 EN, bit1 AUTO (auto-reload), bit2 IE (interrupt enable); bits 31:3 read 0, write ignored.
- LOAD (addr 1): 32-bit period value, R/W.
- COUNT (addr 2): current counter, read-only; writes ignored.
- STATUS (addr 3): bit0 EXP (expired); write 1 to bit0 clears, write 0 no effect; other bits read 0.
- Reads: data_o = sel_i ? selected register (zero-extended) : 0; combinational, no side effects.
- Tick: every clk_i cycle (prescaler out) or prescaler terminal pulse (prescaler in).
- States: IDLE, RUN, DONE. Reset -> IDLE.
- IDLE/DONE + CTRL write with EN=1: COUNT <= LOAD, -> RUN.
- RUN + CTRL write with EN=1: AUTO/IE update only, no restart, COUNT unchanged.
- Any state + CTRL write with EN=0: -> IDLE, COUNT holds value, EXP untouched.
- RUN, tick, COUNT != 0: COUNT <= COUNT - 1.
- RUN, tick, COUNT == 0: EXP <= 1; AUTO=1 -> COUNT <= LOAD, stay RUN; AUTO=0 -> EN <= 0, -> DONE, COUNT stays 0.
- Period = LOAD + 1 ticks. LOAD=0 with AUTO=1 expires on every tick.
- LOAD written during RUN: used at next reload/start only; current count not affected.
- irq_o = EXP & IE, registered.
- Reset values: CTRL 0, LOAD 0, COUNT 0, EXP 0, irq_o 0, state IDLE, prescaler 0.

## Timing
- Writes take effect at the clk_i edge where sel_i & we_i are high; visible on read the following cycle.
- Start latency: CTRL EN write at edge N -> COUNT = LOAD after N; first decrement at first tick after N.
- Expiry: edge where COUNT==0 tick occurs sets EXP; irq_o rises one edge later.
- Simultaneous STATUS clear and expiry in the same cycle: expiry wins, EXP stays 1.
- Simultaneous CTRL EN=0 write and expiry: write wins; -> IDLE, EXP not set.
- Simultaneous CTRL EN=1 start write in DONE and old EXP=1: EXP remains until cleared by software.
- rst_i asserted mid-RUN: all state returns to reset values immediately, irq_o drops asynchronously.
- Counter arithmetic 32-bit unsigned; no underflow since decrement only when COUNT != 0.

## Configuration
- Macro COUNTDOWN_TIMER_PRESCALER_EN.
- Defined: 8-bit prescaler counting 0..PRESCALE_DIV-1, enabled only in RUN; tick = terminal value; prescaler clears on start, on leaving RUN, and on reset. Period = (LOAD+1)*PRESCALE_DIV cycles.
- Undefined: no prescaler logic, PRESCALE_DIV ignored, tick every cycle; period = LOAD+1 cycles.

## Test plan
- Reset then read all four addresses with sel_i=1 -> 0; sel_i=0 with any addr -> data_o 0.
- LOAD=5, CTRL=0x5 (EN, IE), no prescaler -> COUNT 5,4,..,0; EXP set 6 ticks after start; irq_o one cycle later; state DONE, CTRL reads 0x4.
- LOAD=2, CTRL=0x3 (EN, AUTO) -> EXP every 3 cycles; write STATUS=1 in same cycle as expiry -> EXP remains 1.
- During RUN with COUNT=10, write LOAD=100 -> count continues 9,8..; after expiry with AUTO reload value is 100.
- During RUN write CTRL=0 -> COUNT freezes at current value, no EXP; assert rst_i mid-RUN -> all registers 0, irq_o 0 immediately.
- With COUNTDOWN_TIMER_PRESCALER_EN, PRESCALE_DIV=4, LOAD=1 -> EXP after exactly 8 cycles from start.

Source files
------------

// File: rtl/countdown_timer_if.sv
// Peripheral bus bundle for the M10 countdown timer: select/write strobe,
// 2-bit register index, write data and OR-combinable read data.
interface countdown_timer_if;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output sel, output we, output addr, output wdata, input rdata);
    modport slave  (input sel, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/countdown_timer.sv
// Processor-writable down-counting timer with expiry flag, level irq and auto-reload.
// Optional tick prescaler compiled in with COUNTDOWN_TIMER_PRESCALER_EN.
//
// state | meaning
// IDLE  | stopped (reset or EN cleared), COUNT holds last value
// RUN   | counting down one step per tick
// DONE  | one-shot expired, COUNT parked at 0
module countdown_timer #(
    parameter int PRESCALE_DIV = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    countdown_timer_if.slave   bus,
    output logic               irq_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_LOAD   = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;
    localparam logic [1:0] A_STATUS = 2'd3;

    state_t      state_q, state_d;
    logic        auto_q, auto_d;
    logic        ie_q, ie_d;
    logic [31:0] load_q, load_d;
    logic [31:0] count_q, count_d;
    logic        exp_q, exp_d;
    logic        irq_q;
    logic        tick;

    logic wr_en;
    logic ctrl_wr;
    logic load_wr;
    logic status_wr;

    assign wr_en     = bus.sel & bus.we;
    assign ctrl_wr   = wr_en && (bus.addr == A_CTRL);
    assign load_wr   = wr_en && (bus.addr == A_LOAD);
    assign status_wr = wr_en && (bus.addr == A_STATUS);

`ifdef COUNTDOWN_TIMER_PRESCALER_EN
    localparam logic [7:0] PSC_LAST = 8'(PRESCALE_DIV - 1);

    logic [7:0] psc_q, psc_d;

    assign tick = (state_q == ST_RUN) && (psc_q == PSC_LAST);

    // Prescaler only runs while staying in RUN, so every start begins a full division.
    always_comb begin
        psc_d = 8'd0;
        if ((state_q == ST_RUN) && (state_d == ST_RUN) && !tick) begin
            psc_d = psc_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            psc_q <= 8'd0;
        end else begin
            psc_q <= psc_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        auto_d  = auto_q;
        ie_d    = ie_q;
        load_d  = load_q;
        count_d = count_q;
        exp_d   = exp_q;

        if (load_wr) begin
            load_d = bus.wdata;
        end
        if (status_wr && bus.wdata[0]) begin
            exp_d = 1'b0;
        end
        if (ctrl_wr) begin
            auto_d = bus.wdata[1];
            ie_d   = bus.wdata[2];
        end

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (ctrl_wr) begin
                    if (bus.wdata[0]) begin
                        count_d = load_q;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RUN: begin
                // A stop write overrides a same-cycle decrement or expiry.
                if (ctrl_wr && !bus.wdata[0]) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (count_q != 32'd0) begin
                        count_d = count_q - 32'd1;
                    end else begin
                        exp_d = 1'b1;
                        if (auto_q) begin
                            count_d = load_q;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            auto_q  <= 1'b0;
            ie_q    <= 1'b0;
            load_q  <= 32'd0;
            count_q <= 32'd0;
            exp_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            auto_q  <= auto_d;
            ie_q    <= ie_d;
            load_q  <= load_d;
            count_q <= count_d;
            exp_q   <= exp_d;
            irq_q   <= exp_q & ie_q;
        end
    end

    assign irq_o = irq_q;

    // EN reads back as "currently running"; DONE and IDLE both report 0.
    always_comb begin
        bus.rdata = 32'd0;
        if (bus.sel) begin
            unique case (bus.addr)
                A_CTRL:   bus.rdata = {29'd0, ie_q, auto_q, (state_q == ST_RUN)};
                A_LOAD:   bus.rdata = load_q;
                A_COUNT:  bus.rdata = count_q;
                A_STATUS: bus.rdata = {31'd0, exp_q};
                default:  bus.rdata = 32'd0;
            endcase
        end
    end

endmodule
